// File: rtl/cache_pkg.sv
// cache_pkg
// Shared definitions for the MEM-stage data cache slice: FSM state encoding
// for the miss/write-through controller and the default datapath widths.
package cache_pkg;

   localparam int DATA_WIDTH   = 32;
   localparam int ADDR_WIDTH   = 32;
   localparam int SET_WIDTH    = 3;
   localparam int OFFSET_WIDTH = 2;   // byte offset within a 32-bit word

   typedef enum logic [2:0] {
      IDLE,
      RD_REQ,
      RD_WAIT,
      FILL,
      WR_REQ
   } miss_state_t;

endpackage

// File: rtl/sat_counter.sv
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
// Ports:
//   clk   - clock, all updates on posedge
//   rst   - synchronous active-high reset, clears the count
//   inc   - add one this cycle (ignored once saturated)
//   count - current count value
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg <= '0;
      end else if (inc && (count_reg != {WIDTH{1'b1}})) begin
         count_reg <= count_reg + WIDTH'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/cache_miss_handler.sv
// cache_miss_handler
// Miss and write-through controller between the direct-mapped data cache and
// the multi-cycle data memory. Load misses stall the pipeline, fetch the word
// and fill the cache; every store is written through to memory and updates the
// cache only when it hits. Load misses are counted in a saturating counter.
// Ports:
//   clk, rst                      - clock and synchronous active-high reset
//   access_valid/access_write     - MEM stage access present / is a store
//   address, write_data           - access byte address and store data
//   cache_hit                     - cache lookup result for address
//   stall                         - combinational pipeline freeze
//   mem_req_valid/ready/write     - memory request handshake and direction
//   mem_req_addr/wdata            - word-aligned request address and data
//   mem_resp_valid/data           - one-cycle read response from memory
//   fill_en/fill_addr/fill_data   - cache write port
//   miss_count                    - saturating load-miss count
module cache_miss_handler #(
   parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  access_valid,
   input  logic                  access_write,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic [DATA_WIDTH-1:0] write_data,
   input  logic                  cache_hit,
   output logic                  stall,
   output logic                  mem_req_valid,
   input  logic                  mem_req_ready,
   output logic                  mem_req_write,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   output logic [DATA_WIDTH-1:0] mem_req_wdata,
   input  logic                  mem_resp_valid,
   input  logic [DATA_WIDTH-1:0] mem_resp_data,
   output logic                  fill_en,
   output logic [ADDR_WIDTH-1:0] fill_addr,
   output logic [DATA_WIDTH-1:0] fill_data,
   output logic [CNT_WIDTH-1:0]  miss_count
);

   import cache_pkg::*;

   miss_state_t           state_reg, state_next;
   logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
   logic [DATA_WIDTH-1:0] data_reg, data_next;
   // Set for the single IDLE cycle right after a store is accepted by memory.
   // The pipeline still presents that store in this cycle (it was frozen),
   // so it must be retired here rather than started again.
   logic                  wr_done_reg, wr_done_next;
   logic                  miss_inc;
   logic                  new_access;
   logic [ADDR_WIDTH-1:0] aligned_addr;

   assign aligned_addr = {address[ADDR_WIDTH-1:OFFSET_WIDTH], {OFFSET_WIDTH{1'b0}}};
   assign new_access   = access_valid && !wr_done_reg;

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         addr_reg    <= '0;
         data_reg    <= '0;
         wr_done_reg <= 1'b0;
      end else begin
         state_reg   <= state_next;
         addr_reg    <= addr_next;
         data_reg    <= data_next;
         wr_done_reg <= wr_done_next;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_next   = state_reg;
      addr_next    = addr_reg;
      data_next    = data_reg;
      wr_done_next = 1'b0;
      case (state_reg)
         IDLE: begin
            if (new_access) begin
               if (access_write) begin
                  addr_next  = aligned_addr;
                  data_next  = write_data;
                  state_next = WR_REQ;
               end else if (!cache_hit) begin
                  addr_next  = aligned_addr;
                  state_next = RD_REQ;
               end
            end
         end
         RD_REQ: begin
            if (mem_req_ready) state_next = RD_WAIT;
         end
         RD_WAIT: begin
            // Responses are only honoured here; anything else is stale.
            if (mem_resp_valid) begin
               data_next  = mem_resp_data;
               state_next = FILL;
            end
         end
         FILL: begin
            state_next = IDLE;
         end
         WR_REQ: begin
            if (mem_req_ready) begin
               state_next   = IDLE;
               wr_done_next = 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Outputs
   always_comb begin
      stall         = 1'b0;
      mem_req_valid = 1'b0;
      mem_req_write = 1'b0;
      fill_en       = 1'b0;
      fill_addr     = addr_reg;
      fill_data     = data_reg;
      miss_inc      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (new_access) begin
               if (access_write) begin
                  stall     = 1'b1;
                  // Store hit updates the cache immediately; a miss does not allocate.
                  fill_en   = cache_hit;
                  fill_addr = address;
                  fill_data = write_data;
               end else if (!cache_hit) begin
                  stall    = 1'b1;
                  miss_inc = 1'b1;
               end
            end
         end
         RD_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
         end
         RD_WAIT: begin
            stall = 1'b1;
         end
         FILL: begin
            stall   = 1'b1;
            fill_en = 1'b1;
         end
         WR_REQ: begin
            stall         = 1'b1;
            mem_req_valid = 1'b1;
            mem_req_write = 1'b1;
         end
         default: begin
            stall = 1'b0;
         end
      endcase
   end

   // Request fields come only from the latched registers so they stay stable
   // while the request waits for ready.
   assign mem_req_addr  = addr_reg;
   assign mem_req_wdata = data_reg;

   sat_counter #(
      .WIDTH(CNT_WIDTH)
   ) u_miss_counter (
      .clk  (clk),
      .rst  (rst),
      .inc  (miss_inc),
      .count(miss_count)
   );

endmodule

// File: tb/tb_cache_miss_handler.sv
module tb_cache_miss_handler;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int CW = 4;
   localparam int CNT_MAX = 15;

   logic          clk = 1'b0;
   logic          rst;
   logic          access_valid;
   logic          access_write;
   logic [AW-1:0] address;
   logic [DW-1:0] write_data;
   logic          cache_hit;
   logic          stall;
   logic          mem_req_valid;
   logic          mem_req_ready;
   logic          mem_req_write;
   logic [AW-1:0] mem_req_addr;
   logic [DW-1:0] mem_req_wdata;
   logic          mem_resp_valid;
   logic [DW-1:0] mem_resp_data;
   logic          fill_en;
   logic [AW-1:0] fill_addr;
   logic [DW-1:0] fill_data;
   logic [CW-1:0] miss_count;

   cache_miss_handler #(
      .DATA_WIDTH(DW),
      .ADDR_WIDTH(AW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .access_valid  (access_valid),
      .access_write  (access_write),
      .address       (address),
      .write_data    (write_data),
      .cache_hit     (cache_hit),
      .stall         (stall),
      .mem_req_valid (mem_req_valid),
      .mem_req_ready (mem_req_ready),
      .mem_req_write (mem_req_write),
      .mem_req_addr  (mem_req_addr),
      .mem_req_wdata (mem_req_wdata),
      .mem_resp_valid(mem_resp_valid),
      .mem_resp_data (mem_resp_data),
      .fill_en       (fill_en),
      .fill_addr     (fill_addr),
      .fill_data     (fill_data),
      .miss_count    (miss_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } xact_t;

   xact_t req_q[$];
   xact_t fill_q[$];

   int tests = 0;
   int fails = 0;
   int exp_cnt = 0;

   // Memory model knobs, set by the stimulus before each transaction
   int            ready_delay = 0;
   int            resp_delay  = 1;
   logic [DW-1:0] resp_word   = '0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compares every request and every fill the DUT presents
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         if (mem_req_valid === 1'b1) begin
            if (req_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_req: got addr 0x%0h write %0b, required no request",
                        mem_req_addr, mem_req_write);
            end else begin
               check("req_write", 64'(mem_req_write), 64'(req_q[0].wr));
               check("req_addr", 64'(mem_req_addr), 64'(req_q[0].addr));
               if (req_q[0].wr) check("req_wdata", 64'(mem_req_wdata), 64'(req_q[0].data));
               if (mem_req_ready === 1'b1) void'(req_q.pop_front());
            end
         end
         if (fill_en === 1'b1) begin
            if (fill_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_fill: got addr 0x%0h data 0x%0h, required no fill",
                        fill_addr, fill_data);
            end else begin
               check("fill_addr", 64'(fill_addr), 64'(fill_q[0].addr));
               check("fill_data", 64'(fill_data), 64'(fill_q[0].data));
               void'(fill_q.pop_front());
            end
         end
      end
   end

   // Memory model: ready after ready_delay cycles of valid, read data
   // resp_delay cycles after acceptance.
   initial begin
      int   wait_cnt;
      int   resp_cnt;
      logic acc;
      logic acc_wr;
      wait_cnt       = 0;
      resp_cnt       = 0;
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      forever begin
         @(negedge clk);
         acc    = (mem_req_valid === 1'b1) && mem_req_ready;
         acc_wr = mem_req_write;
         @(posedge clk);
         #1;
         mem_resp_valid = 1'b0;
         if (acc && !acc_wr) resp_cnt = resp_delay;
         if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
               mem_resp_valid = 1'b1;
               mem_resp_data  = resp_word;
            end
         end
         if (acc) wait_cnt = 0;
         if (mem_req_valid === 1'b1) begin
            mem_req_ready = (wait_cnt >= ready_delay);
            wait_cnt++;
         end else begin
            mem_req_ready = 1'b0;
            wait_cnt      = 0;
         end
      end
   end

   // One access presented until the DUT releases stall
   task automatic run_access(input string tag, input logic wr, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wd, input logic hit, input logic [DW-1:0] rdata,
                             input int rdy, input int exp_stall, input int exp_fill_idx,
                             input int exp_req_cycles);
      int            stall_n;
      int            fill_idx;
      int            req_n;
      int            cyc;
      logic          done;
      xact_t         e;
      logic [AW-1:0] al;
      stall_n     = 0;
      fill_idx    = -1;
      req_n       = 0;
      cyc         = 0;
      done        = 1'b0;
      al          = {addr[AW-1:2], 2'b00};
      ready_delay = rdy;
      resp_word   = rdata;
      if (wr) begin
         e.wr = 1'b1; e.addr = al; e.data = wd;
         req_q.push_back(e);
         if (hit) begin
            e.addr = addr;
            fill_q.push_back(e);
         end
      end else if (!hit) begin
         e.wr = 1'b0; e.addr = al; e.data = '0;
         req_q.push_back(e);
         e.data = rdata;
         fill_q.push_back(e);
         if (exp_cnt < CNT_MAX) exp_cnt++;
      end
      access_valid = 1'b1;
      access_write = wr;
      address      = addr;
      write_data   = wd;
      cache_hit    = hit;
      while (!done && cyc < 50) begin
         @(negedge clk);
         if (mem_req_valid === 1'b1) req_n++;
         if (fill_en === 1'b1 && fill_idx < 0) fill_idx = cyc;
         if (stall === 1'b1) stall_n++;
         else done = 1'b1;
         cyc++;
         @(posedge clk);
         #1;
         // After the fill the re-presented load hits in the cache
         if (fill_idx >= 0 && !wr) cache_hit = 1'b1;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL %s_timeout: stall still high after %0d cycles, required release", tag, cyc);
      end
      check({tag, "_stall_cycles"}, 64'(stall_n), 64'(exp_stall));
      check({tag, "_fill_cycle"}, 64'(fill_idx), 64'(exp_fill_idx));
      check({tag, "_req_cycles"}, 64'(req_n), 64'(exp_req_cycles));
      check({tag, "_miss_count"}, 64'(miss_count), 64'(exp_cnt));
      access_valid = 1'b0;
      access_write = 1'b0;
      cache_hit    = 1'b0;
      $display("[TB] %s %s addr=0x%08h stall_cycles=%0d miss_count=%0d",
               tag, wr ? "store" : "load", addr, stall_n, miss_count);
   endtask

   initial begin
      xact_t e;
      rst          = 1'b1;
      access_valid = 1'b0;
      access_write = 1'b0;
      address      = '0;
      write_data   = '0;
      cache_hit    = 1'b0;

      // Power-on reset
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check("reset_stall", 64'(stall), 64'(0));
      check("reset_req_valid", 64'(mem_req_valid), 64'(0));
      check("reset_req_write", 64'(mem_req_write), 64'(0));
      check("reset_fill_en", 64'(fill_en), 64'(0));
      check("reset_miss_count", 64'(miss_count), 64'(0));
      $display("[TB] reset done");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset while waiting for a slow read; the late response must be ignored
      resp_delay  = 8;
      ready_delay = 0;
      resp_word   = 32'hBAD0_BAD0;
      e.wr = 1'b0; e.addr = 32'h0000_0040; e.data = '0;
      req_q.push_back(e);
      access_valid = 1'b1;
      access_write = 1'b0;
      address      = 32'h0000_0040;
      cache_hit    = 1'b0;
      @(negedge clk);
      check("rst_mid_miss_stall", 64'(stall), 64'(1));
      @(posedge clk);
      #1;
      access_valid = 1'b0;
      @(negedge clk);
      check("rst_mid_rd_req", 64'(mem_req_valid), 64'(1));
      @(posedge clk);
      #1;
      @(negedge clk);
      check("rst_mid_count_before", 64'(miss_count), 64'(1));
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      exp_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("rst_after_stall", 64'(stall), 64'(0));
         check("rst_after_req_valid", 64'(mem_req_valid), 64'(0));
         check("rst_after_fill_en", 64'(fill_en), 64'(0));
         @(posedge clk);
         #1;
      end
      check("rst_after_miss_count", 64'(miss_count), 64'(0));
      $display("[TB] reset mid RD_WAIT, miss_count=%0d", miss_count);
      resp_delay = 1;

      // Main traffic
      run_access("load_miss", 1'b0, 32'h0000_0014, '0, 1'b0, 32'hDEAD_BEEF, 0, 4, 3, 1);
      run_access("load_hit", 1'b0, 32'h0000_0020, '0, 1'b1, '0, 0, 0, -1, 0);
      run_access("store_hit", 1'b1, 32'h0000_0008, 32'h1234_5678, 1'b1, '0, 3, 5, 0, 4);
      run_access("store_miss", 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 1'b0, '0, 0, 2, -1, 1);
      run_access("load_unaligned", 1'b0, 32'h0000_0027, '0, 1'b0, 32'h0BAD_CAFE, 1, 5, 4, 2);

      // Drive the counter into saturation
      for (int i = 0; i < 20; i++) begin
         run_access("sat_miss", 1'b0, 32'h0000_0100 + 32'(i * 4), '0, 1'b0,
                    32'h0000_1000 + 32'(i), 0, 4, 3, 1);
      end
      check("sat_final_count", 64'(miss_count), 64'(CNT_MAX));

      repeat (3) @(posedge clk);
      #1;
      check("req_queue_drained", 64'(req_q.size()), 64'(0));
      check("fill_queue_drained", 64'(fill_q.size()), 64'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule
